// File: rtl/nou_issue.sv
// -----------------------------------------------------------------------------
// nou_issue
//   Issue stage fed by the head of the XoCC Request Queue (XRQ). Each cycle
//   the head entry is either popped (decode_issue_ack) or left waiting. A
//   popped entry with vld set is dispatched one cycle later to exactly one
//   execution unit (BRR, PWRR, SPIDR, SPRR, IRR). Dispatch is gated by a
//   per-unit credit counter. An SPIDR must be followed by an SPRR with the
//   same sid; an SPRR that breaks the pair is redirected to IRR.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   xrq_entry_in        {unit_mask, cmd, sid, vld} head entry
//   xrq_entry_in_valid  head entry present
//   decode_issue_ack    combinational pop of the XRQ head
//   unit_vld_o          one-hot dispatch strobe (registered)
//   unit_sid_o          dispatched sid (holds when idle)
//   unit_cmd_o          dispatched command (holds when idle)
//   unit_credit_ret_i   per-unit credit return pulses
//   err_o               [0] pair violation, [1] bad mask / credit overflow
//   busy_o              FSM in PAIR or any credit outstanding
// -----------------------------------------------------------------------------
module nou_issue #(
    parameter int CMD_W   = 64,
    parameter int SID_W   = 8,
    parameter int UOV     = 5,
    parameter int CREDITS = 4,
    parameter int ENTRY_W = 1 + SID_W + CMD_W + UOV
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ENTRY_W-1:0] xrq_entry_in,
    input  logic               xrq_entry_in_valid,
    output logic               decode_issue_ack,
    output logic [UOV-1:0]     unit_vld_o,
    output logic [SID_W-1:0]   unit_sid_o,
    output logic [CMD_W-1:0]   unit_cmd_o,
    input  logic [UOV-1:0]     unit_credit_ret_i,
    output logic [1:0]         err_o,
    output logic               busy_o
);

    localparam logic [UOV-1:0] SPIDR_M  = UOV'(4);
    localparam logic [UOV-1:0] SPRR_M   = UOV'(8);
    localparam logic [UOV-1:0] IRR_M    = UOV'(16);
    localparam logic [2:0]     CRED_MAX = 3'(CREDITS);

    typedef enum logic {IDLE, PAIR} state_t;

    state_t                 state_q, state_d;
    logic [SID_W-1:0]       pair_sid_q, pair_sid_d;
    logic [UOV-1:0][2:0]    cred_q, cred_d;
    logic [UOV-1:0]         unit_vld_q, unit_vld_d;
    logic [SID_W-1:0]       unit_sid_q, unit_sid_d;
    logic [CMD_W-1:0]       unit_cmd_q, unit_cmd_d;
    logic [1:0]             err_q, err_d;
    logic                   busy_q, busy_d;

    // Entry fields
    logic                   e_vld;
    logic [SID_W-1:0]       e_sid;
    logic [CMD_W-1:0]       e_cmd;
    logic [UOV-1:0]         e_mask;

    assign e_vld  = xrq_entry_in[0];
    assign e_sid  = xrq_entry_in[SID_W:1];
    assign e_cmd  = xrq_entry_in[SID_W+CMD_W:SID_W+1];
    assign e_mask = xrq_entry_in[ENTRY_W-1:ENTRY_W-UOV];

    logic                   mask_onehot;
    logic                   is_sprr;
    logic                   pair_break;
    logic [UOV-1:0]         tgt;
    logic [UOV-1:0]         cred_avail;
    logic                   ack;
    logic                   accept;
    logic [UOV-1:0]         dec;
    logic [UOV-1:0]         ovf;
    logic                   all_full;

    // Target selection and acknowledge
    always_comb begin
        mask_onehot = (e_mask != '0) && ((e_mask & (e_mask - UOV'(1))) == '0);
        is_sprr     = (e_mask == SPRR_M);
        pair_break  = (state_q == PAIR) && is_sprr && (e_sid != pair_sid_q);
        tgt         = mask_onehot ? e_mask : IRR_M;
        if (pair_break) tgt = IRR_M;
        // A return arriving this cycle already counts as an available credit,
        // so a stalled head is popped in the same cycle its credit comes back.
        for (int i = 0; i < UOV; i++)
            cred_avail[i] = (cred_q[i] != 3'd0) || unit_credit_ret_i[i];
        ack    = xrq_entry_in_valid && (!e_vld || ((tgt & cred_avail) != '0));
        accept = ack && e_vld;
        dec    = accept ? tgt : '0;
    end

    assign decode_issue_ack = ack;

    // Credit counters: return with no dispatch at full saturates and flags
    always_comb begin
        all_full = 1'b1;
        for (int i = 0; i < UOV; i++) begin
            cred_d[i] = cred_q[i];
            ovf[i]    = 1'b0;
            if (dec[i] && !unit_credit_ret_i[i]) begin
                cred_d[i] = cred_q[i] - 3'd1;
            end else if (!dec[i] && unit_credit_ret_i[i]) begin
                if (cred_q[i] == CRED_MAX) ovf[i] = 1'b1;
                else                       cred_d[i] = cred_q[i] + 3'd1;
            end
            if (cred_d[i] != CRED_MAX) all_full = 1'b0;
        end
    end

    // Pairing FSM and registered outputs
    always_comb begin
        state_d    = state_q;
        pair_sid_d = pair_sid_q;
        err_d      = 2'b00;
        if (accept) begin
            if (state_q == PAIR)
                err_d[0] = !(is_sprr && (e_sid == pair_sid_q));
            if (e_mask == SPIDR_M) begin
                state_d    = PAIR;
                pair_sid_d = e_sid;
            end else begin
                state_d    = IDLE;
            end
        end
        err_d[1]   = (accept && !mask_onehot) || (ovf != '0);
        unit_vld_d = dec;
        unit_sid_d = accept ? e_sid : unit_sid_q;
        unit_cmd_d = accept ? e_cmd : unit_cmd_q;
        busy_d     = (state_d == PAIR) || !all_full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pair_sid_q <= '0;
            cred_q     <= {UOV{CRED_MAX}};
            unit_vld_q <= '0;
            unit_sid_q <= '0;
            unit_cmd_q <= '0;
            err_q      <= 2'b00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pair_sid_q <= pair_sid_d;
            cred_q     <= cred_d;
            unit_vld_q <= unit_vld_d;
            unit_sid_q <= unit_sid_d;
            unit_cmd_q <= unit_cmd_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign unit_vld_o = unit_vld_q;
    assign unit_sid_o = unit_sid_q;
    assign unit_cmd_o = unit_cmd_q;
    assign err_o      = err_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_nou_issue.sv
// Bench for nou_issue: stimulus tasks push expected dispatches into a
// scoreboard queue tagged with the cycle they are due; a negedge monitor pops
// and compares them against the unit outputs.
module tb_nou_issue;
    localparam int CMD_W = 64, SID_W = 8, UOV = 5;
    localparam int ENTRY_W = 1 + SID_W + CMD_W + UOV;
    localparam logic [4:0] BRR = 5'b00001, PWRR = 5'b00010, SPIDR = 5'b00100,
                           SPRR = 5'b01000, IRR = 5'b10000;

    logic               clk = 1'b0;
    logic               rst;
    logic [ENTRY_W-1:0] xrq_entry_in;
    logic               xrq_entry_in_valid;
    logic               decode_issue_ack;
    logic [UOV-1:0]     unit_vld_o;
    logic [SID_W-1:0]   unit_sid_o;
    logic [CMD_W-1:0]   unit_cmd_o;
    logic [UOV-1:0]     unit_credit_ret_i;
    logic [1:0]         err_o;
    logic               busy_o;

    nou_issue dut (
        .clk(clk), .rst(rst),
        .xrq_entry_in(xrq_entry_in), .xrq_entry_in_valid(xrq_entry_in_valid),
        .decode_issue_ack(decode_issue_ack),
        .unit_vld_o(unit_vld_o), .unit_sid_o(unit_sid_o), .unit_cmd_o(unit_cmd_o),
        .unit_credit_ret_i(unit_credit_ret_i), .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [4:0]  vld;
        logic [7:0]  sid;
        logic [63:0] cmd;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mkcmd(input logic [7:0] s);
        return {s, 24'h00C0DE, 24'hFACE00, s};
    endfunction

    task automatic push(input logic [4:0] v, input logic [7:0] s, input logic [1:0] e);
        exp_t x;
        x.due = cyc + 1; x.vld = v; x.sid = s; x.cmd = mkcmd(s); x.err = e;
        sb.push_back(x);
    endtask

    task automatic drive(input logic v, input logic ev, input logic [4:0] m,
                         input logic [7:0] s, input logic [4:0] ret);
        xrq_entry_in       = {m, mkcmd(s), s, ev};
        xrq_entry_in_valid = v;
        unit_credit_ret_i  = ret;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            n_chk++; n_fail++;
            e = sb.pop_front();
            $display("FAIL sb_missing: dispatch due cycle %0d not seen (now %0d), want vld %b sid %0d", e.due, cyc, e.vld, e.sid);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            n_chk++;
            if (unit_vld_o !== e.vld || err_o !== e.err ||
                (e.vld != 5'b0 && (unit_sid_o !== e.sid || unit_cmd_o !== e.cmd))) begin
                n_fail++;
                $display("FAIL dispatch@%0d: got vld %b sid %h cmd %h err %b, want vld %b sid %h cmd %h err %b",
                         cyc, unit_vld_o, unit_sid_o, unit_cmd_o, err_o, e.vld, e.sid, e.cmd, e.err);
            end
        end else begin
            n_chk++;
            if (unit_vld_o !== 5'b0 || err_o !== 2'b0) begin
                n_fail++;
                $display("FAIL unexpected@%0d: got vld %b err %b, want 0 0", cyc, unit_vld_o, err_o);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        xrq_entry_in = '0; xrq_entry_in_valid = 1'b0; unit_credit_ret_i = '0;
        repeat (3) @(posedge clk);
        #1; @(negedge clk);
        n_chk++;
        if ({decode_issue_ack, unit_vld_o, unit_sid_o, unit_cmd_o, err_o, busy_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack %b vld %b sid %h cmd %h err %b busy %b, want all 0",
                     decode_issue_ack, unit_vld_o, unit_sid_o, unit_cmd_o, err_o, busy_o);
        end
        tick();
        rst = 1'b0;
    endtask

    // Fill a unit's four credits, then check the fifth entry stalls.
    task automatic fill_unit(input logic [4:0] m, input logic [7:0] s0, input string nm);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, m, s0 + 8'(i), 5'b0);
            n_chk++;
            if (decode_issue_ack !== 1'b1) begin
                n_fail++; $display("FAIL %s_ack[%0d]: got %b want 1", nm, i, decode_issue_ack);
            end
            push(m, s0 + 8'(i), 2'b00);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, m, s0 + 8'd4, 5'b0);
            n_chk++;
            if (decode_issue_ack !== 1'b0) begin
                n_fail++; $display("FAIL %s_stall[%0d]: got ack %b want 0", nm, k, decode_issue_ack);
            end
            n_chk++;
            if (busy_o !== 1'b1) begin
                n_fail++; $display("FAIL %s_busy_stall: got %b want 1", nm, busy_o);
            end
            tick();
        end
    endtask

    task automatic check_idle(input string nm);
        drive(0, 0, 5'b0, 8'd0, 5'b0);
        n_chk++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL %s_busy_clear: got %b want 0", nm, busy_o);
        end
        tick();
    endtask

    task automatic test_brr_credits();
        fill_unit(BRR, 8'd1, "brr");
        // credit return pops the stalled head in the same cycle
        drive(1, 1, BRR, 8'd5, 5'b00001);
        n_chk++;
        if (decode_issue_ack !== 1'b1) begin
            n_fail++; $display("FAIL brr_ret_ack: got %b want 1", decode_issue_ack);
        end
        push(BRR, 8'd5, 2'b00);
        tick();
        repeat (4) begin drive(0, 0, 5'b0, 8'd0, 5'b00001); tick(); end
        check_idle("brr");
    endtask

    task automatic test_pair_ok();
        drive(1, 1, SPIDR, 8'd7, 5'b0);
        n_chk++;
        if (decode_issue_ack !== 1'b1) begin n_fail++; $display("FAIL pair_ok_ack0: got %b want 1", decode_issue_ack); end
        push(SPIDR, 8'd7, 2'b00); tick();
        drive(1, 1, SPRR, 8'd7, 5'b0);
        n_chk++;
        if (decode_issue_ack !== 1'b1) begin n_fail++; $display("FAIL pair_ok_ack1: got %b want 1", decode_issue_ack); end
        push(SPRR, 8'd7, 2'b00); tick();
        drive(0, 0, 5'b0, 8'd0, SPIDR);
        n_chk++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL pair_ok_busy0: got %b want 1", busy_o); end
        tick();
        drive(0, 0, 5'b0, 8'd0, SPRR);
        n_chk++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL pair_ok_busy1: got %b want 1", busy_o); end
        tick();
        check_idle("pair_ok");
    endtask

    task automatic test_pair_break();
        drive(1, 1, SPIDR, 8'd7, 5'b0);
        push(SPIDR, 8'd7, 2'b00); tick();
        drive(1, 1, SPRR, 8'd9, 5'b0);
        n_chk++;
        if (decode_issue_ack !== 1'b1) begin n_fail++; $display("FAIL pair_break_ack: got %b want 1", decode_issue_ack); end
        push(IRR, 8'd9, 2'b01); tick();
        drive(0, 0, 5'b0, 8'd0, SPIDR | IRR); tick();
        check_idle("pair_break");
    endtask

    task automatic test_bad_mask();
        drive(1, 0, BRR, 8'h11, 5'b0);
        n_chk++;
        if (decode_issue_ack !== 1'b1) begin n_fail++; $display("FAIL drop_ack: got %b want 1", decode_issue_ack); end
        tick();
        drive(1, 1, 5'b00011, 8'h22, 5'b0);
        n_chk++;
        if (decode_issue_ack !== 1'b1) begin n_fail++; $display("FAIL badmask_ack: got %b want 1", decode_issue_ack); end
        push(IRR, 8'h22, 2'b10); tick();
        drive(0, 0, 5'b0, 8'd0, IRR); tick();
        check_idle("bad_mask");
    endtask

    task automatic test_pwrr_credit();
        drive(1, 1, PWRR, 8'h30, PWRR);
        n_chk++;
        if (decode_issue_ack !== 1'b1) begin n_fail++; $display("FAIL pwrr_ack: got %b want 1", decode_issue_ack); end
        push(PWRR, 8'h30, 2'b00); tick();
        drive(0, 0, 5'b0, 8'd0, PWRR);
        push(5'b0, 8'd0, 2'b10); tick();
        // counter must still be at 4: exactly four more PWRR fit
        fill_unit(PWRR, 8'h40, "pwrr");
        repeat (4) begin drive(0, 0, 5'b0, 8'd0, PWRR); tick(); end
        check_idle("pwrr");
    endtask

    task automatic test_reset_in_pair();
        drive(1, 1, BRR, 8'd1, 5'b0);
        push(BRR, 8'd1, 2'b00); tick();
        drive(1, 1, SPIDR, 8'd3, 5'b0);
        push(SPIDR, 8'd3, 2'b00); tick();
        drive(0, 0, 5'b0, 8'd0, 5'b0);
        n_chk++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rst_pair_busy: got %b want 1", busy_o); end
        rst = 1'b1;
        unit_credit_ret_i = BRR;
        tick();
        unit_credit_ret_i = '0;
        @(negedge clk);
        n_chk++;
        if ({unit_vld_o, unit_sid_o, unit_cmd_o, err_o, busy_o} !== '0) begin
            n_fail++;
            $display("FAIL rst_pair_outputs: got vld %b sid %h cmd %h err %b busy %b, want all 0",
                     unit_vld_o, unit_sid_o, unit_cmd_o, err_o, busy_o);
        end
        tick();
        rst = 1'b0;
        drive(1, 1, SPRR, 8'd5, 5'b0);
        n_chk++;
        if (decode_issue_ack !== 1'b1) begin n_fail++; $display("FAIL lone_sprr_ack: got %b want 1", decode_issue_ack); end
        push(SPRR, 8'd5, 2'b00); tick();
        fill_unit(BRR, 8'h50, "rst_brr");
        drive(0, 0, 5'b0, 8'd0, BRR | SPRR); tick();
        repeat (3) begin drive(0, 0, 5'b0, 8'd0, BRR); tick(); end
        check_idle("rst_pair");
    endtask

    initial begin
        test_reset();
        test_brr_credits();
        test_pair_ok();
        test_pair_break();
        test_bad_mask();
        test_pwrr_credit();
        test_reset_in_pair();
        repeat (3) tick();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
